// File: rtl/reset_seq_pkg.sv
// Shared types and width helpers for the reset sequencer and related board-level blocks.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      SETTLE  = 2'd0,
      STAGGER = 2'd1,
      DONE    = 2'd2
   } seq_state_t;

   // $clog2 of 1 is 0; counters still need at least one bit.
   function automatic int width_min1(input int range_val);
      int w;
      w = $clog2(range_val);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/btn_synchroniser.sv
// Multi-stage flip-flop synchroniser for asynchronous board inputs; clears to 0 on nReset.
module btn_synchroniser #(
   parameter int SYNC_STAGES = 2
) (
   input  logic Clk,
   input  logic nReset,
   input  logic async_i,
   output logic sync_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      end
   end

   assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / button reset generator: holds all channels for a settle time, then
// releases them one by one in index order with a fixed gap, raising Done at the end.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int CHANNELS    = 4,
   parameter int COUNT_WIDTH = 23,
   parameter int STAGE_GAP   = 1024,
   parameter int SYNC_STAGES = 2
) (
   input  logic                Clk,
   input  logic                nReset,
   input  logic                BTNS,
   input  logic                SoftReq,
   output logic [CHANNELS-1:0] Reset,
   output logic                Done
);

   localparam int GAP_W = width_min1(STAGE_GAP);
   localparam int IDX_W = width_min1(CHANNELS);

   localparam logic [COUNT_WIDTH-1:0] SETTLE_LAST = '1;
   localparam logic [GAP_W-1:0]       GAP_LAST    = GAP_W'(STAGE_GAP - 1);
   localparam logic [IDX_W-1:0]       IDX_LAST    = IDX_W'(CHANNELS - 1);

   seq_state_t             state_q;
   logic [COUNT_WIDTH-1:0] settle_cnt_q;
   logic [GAP_W-1:0]       gap_cnt_q;
   logic [IDX_W-1:0]       idx_q;
   logic [CHANNELS-1:0]    reset_q;
   logic                   done_q;

   logic                   btn_sync;
   logic                   restart;
   logic [CHANNELS-1:0]    chan_mask;

   btn_synchroniser #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_btn_sync (
      .Clk     (Clk),
      .nReset  (nReset),
      .async_i (BTNS),
      .sync_o  (btn_sync)
   );

   // SoftReq is already synchronous, so it bypasses the synchroniser.
   assign restart = btn_sync | SoftReq;

   // One-hot select of the channel currently due for release.
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_mask
      assign chan_mask[gi] = (idx_q == IDX_W'(gi));
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q      <= SETTLE;
         settle_cnt_q <= '0;
         gap_cnt_q    <= '0;
         idx_q        <= '0;
         reset_q      <= '1;
         done_q       <= 1'b0;
      end else if (restart) begin
         state_q      <= SETTLE;
         settle_cnt_q <= '0;
         gap_cnt_q    <= '0;
         idx_q        <= '0;
         reset_q      <= '1;
         done_q       <= 1'b0;
      end else begin
         case (state_q)
            SETTLE: begin
               // Counter saturates: it is not advanced on the release edge.
               if (settle_cnt_q == SETTLE_LAST) begin
                  reset_q[0] <= 1'b0;
                  if (CHANNELS == 1) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q   <= STAGGER;
                     gap_cnt_q <= '0;
                     idx_q     <= IDX_W'(1);
                  end
               end else begin
                  settle_cnt_q <= settle_cnt_q + COUNT_WIDTH'(1);
               end
            end
            STAGGER: begin
               if (gap_cnt_q == GAP_LAST) begin
                  reset_q   <= reset_q & ~chan_mask;
                  gap_cnt_q <= '0;
                  if (idx_q == IDX_LAST) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end else begin
                  gap_cnt_q <= gap_cnt_q + GAP_W'(1);
               end
            end
            DONE: begin
            end
            default: begin
               state_q <= SETTLE;
            end
         endcase
      end
   end

   assign Reset = reset_q;
   assign Done  = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: four-channel and single-channel instances.
module tb_reset_sequencer;

   logic       Clk;
   logic       nReset;
   logic       BTNS;
   logic       SoftReq;
   logic [3:0] Reset;
   logic       Done;
   logic [0:0] Reset1;
   logic       Done1;

   int checks = 0;
   int errors = 0;

   reset_sequencer #(
      .CHANNELS(4), .COUNT_WIDTH(4), .STAGE_GAP(3), .SYNC_STAGES(2)
   ) dut (
      .Clk(Clk), .nReset(nReset), .BTNS(BTNS), .SoftReq(SoftReq),
      .Reset(Reset), .Done(Done)
   );

   reset_sequencer #(
      .CHANNELS(1), .COUNT_WIDTH(4), .STAGE_GAP(3), .SYNC_STAGES(2)
   ) dut1 (
      .Clk(Clk), .nReset(nReset), .BTNS(BTNS), .SoftReq(SoftReq),
      .Reset(Reset1), .Done(Done1)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Expected four-channel outputs n edges after power-up / restart edge 0.
   function automatic logic [3:0] exp_rst(input int n);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (n < 16 + 3 * i);
      return r;
   endfunction

   function automatic logic exp_done(input int n);
      return (n >= 25);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic check_seq(input string tag, input int n);
      check({tag, "_reset"}, {28'd0, Reset}, {28'd0, exp_rst(n)});
      check({tag, "_done"}, {31'd0, Done}, {31'd0, exp_done(n)});
   endtask

   initial begin
      nReset  = 1'b0;
      BTNS    = 1'b0;
      SoftReq = 1'b0;

      #12;
      check("por_reset", {28'd0, Reset}, 32'hF);
      check("por_done", {31'd0, Done}, 32'd0);
      check("por_reset1", {31'd0, Reset1}, 32'd1);
      check("por_done1", {31'd0, Done1}, 32'd0);

      // Power-up: edge 1 is the first rising edge after nReset goes high.
      tick(1);
      nReset = 1'b1;
      for (int n = 1; n <= 30; n++) begin
         tick(1);
         check_seq("powerup", n);
         check("single_reset", {31'd0, Reset1}, {31'd0, (n < 16)});
         check("single_done", {31'd0, Done1}, {31'd0, (n >= 16)});
      end

      // Button press for 5 edges; synchronised restart is high on edges 3..7.
      BTNS = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         tick(1);
         if (k <= 2) begin
            check("btn_before_sync_reset", {28'd0, Reset}, 32'h0);
            check("btn_before_sync_done", {31'd0, Done}, 32'd1);
         end else if (k <= 7) begin
            check("btn_hold_reset", {28'd0, Reset}, 32'hF);
            check("btn_hold_done", {31'd0, Done}, 32'd0);
         end else begin
            check_seq("btn_release", k - 7);
         end
         if (k == 5) BTNS = 1'b0;
      end

      // Mid-sequence SoftReq at edge 20 with channels 0 and 1 released.
      SoftReq = 1'b1;
      tick(1);
      check("softreq_latency", {28'd0, Reset}, 32'hF);
      SoftReq = 1'b0;
      for (int n = 1; n <= 19; n++) begin
         tick(1);
         check_seq("mid_pre", n);
      end
      SoftReq = 1'b1;
      tick(1);
      check("mid_restart_reset", {28'd0, Reset}, 32'hF);
      check("mid_restart_done", {31'd0, Done}, 32'd0);
      SoftReq = 1'b0;
      for (int n = 1; n <= 16; n++) begin
         tick(1);
         check_seq("mid_post", n);
      end

      // Collision: SoftReq on the settle release edge.
      SoftReq = 1'b1;
      tick(1);
      SoftReq = 1'b0;
      tick(15);
      check("coll_pre", {28'd0, Reset}, 32'hF);
      SoftReq = 1'b1;
      tick(1);
      check("coll_edge16", {28'd0, Reset}, 32'hF);
      SoftReq = 1'b0;
      for (int n = 1; n <= 16; n++) begin
         tick(1);
         check_seq("coll_post", n);
      end
      tick(3);
      check("coll_stagger", {28'd0, Reset}, 32'hC);

      // Asynchronous nReset while in STAGGER, away from any clock edge.
      #2;
      nReset = 1'b0;
      #1;
      check("async_reset", {28'd0, Reset}, 32'hF);
      check("async_done", {31'd0, Done}, 32'd0);
      check("async_reset1", {31'd0, Reset1}, 32'd1);
      tick(2);
      check("async_hold", {28'd0, Reset}, 32'hF);
      nReset = 1'b1;
      for (int n = 1; n <= 25; n++) begin
         tick(1);
         check_seq("rerun", n);
      end
      check("rerun_single_done", {31'd0, Done1}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
